// File: rtl/mmio_responder_if.sv
// ---------------------------------------------------------------------------
// mmio_responder_if
//   MEM-stage data-memory bus as seen by the I/O responder.
//
//   AddrIn   32  byte address from the EX/MEM ALU result
//   DataIn   32  store data from the EX/MEM rs2 value
//   ReadIn    1  load strobe
//   WriteIn   1  store strobe
//   SelOut    1  address falls inside the I/O window (combinational)
//   DataOut  32  load data, zero when no selected read (combinational)
//
//   master: the pipeline side, which drives address, data and strobes.
//   slave : the responder.
// ---------------------------------------------------------------------------
interface mmio_responder_if;
    logic [31:0] AddrIn;
    logic [31:0] DataIn;
    logic        ReadIn;
    logic        WriteIn;
    logic        SelOut;
    logic [31:0] DataOut;

    modport master (
        output AddrIn, DataIn, ReadIn, WriteIn,
        input  SelOut, DataOut
    );

    modport slave (
        input  AddrIn, DataIn, ReadIn, WriteIn,
        output SelOut, DataOut
    );
endinterface

// File: rtl/mmio_responder.sv
// ---------------------------------------------------------------------------
// mmio_responder
//   Answers MEM-stage loads and stores that fall in a 256-byte I/O window.
//   Provides synchronized switches with rising-edge capture, a prescaled
//   32-bit timer with a sticky compare-match flag, and a display register.
//
//   Parameters
//     BASE_ADDR  base of the I/O window, bits [7:0] must be zero
//     TIMER_DIV  clkIn cycles per timer increment, 1..65535
//
//   Ports
//     clkIn    pipeline clock, all state updates on the rising edge
//     rstn     asynchronous active-low reset
//     bus      data-memory bus (slave modport of mmio_responder_if)
//     sw_i     raw board switches, asynchronous to clkIn
//     dispOut  display register value
//     irqOut   copy of the sticky timer-match flag
//
//   Register map (word offsets within the window)
//     0x00 SW_DATA    RO    synchronized switches, zero-extended
//     0x04 SW_EDGE    R/W1C rising edges seen on synchronized switches
//     0x08 TIMER      RW    32-bit up-counter
//     0x0C TIMER_CMP  RW    compare value
//     0x10 STATUS     W1C   bit0 = match flag
//     0x14 DISP       RW    display value
// ---------------------------------------------------------------------------
module mmio_responder #(
    parameter logic [31:0] BASE_ADDR = 32'hFFFF_FF00,
    parameter int unsigned TIMER_DIV = 1
) (
    input  logic             clkIn,
    input  logic             rstn,
    mmio_responder_if.slave  bus,
    input  logic [15:0]      sw_i,
    output logic [31:0]      dispOut,
    output logic             irqOut
);

    // Register word indices (AddrIn[7:2]).
    localparam logic [5:0] OFF_SW_DATA   = 6'd0;
    localparam logic [5:0] OFF_SW_EDGE   = 6'd1;
    localparam logic [5:0] OFF_TIMER     = 6'd2;
    localparam logic [5:0] OFF_TIMER_CMP = 6'd3;
    localparam logic [5:0] OFF_STATUS    = 6'd4;
    localparam logic [5:0] OFF_DISP      = 6'd5;

    localparam logic [15:0] PRE_LAST = 16'(TIMER_DIV - 1);

    // Architectural and synchronizer state.
    logic [15:0] swSync1;
    logic [15:0] swSync2;
    logic [15:0] swHist;
    logic [15:0] swEdge;
    logic [31:0] timerVal;
    logic [15:0] preCnt;
    logic [31:0] timerCmp;
    logic        matchFlag;
    logic [31:0] dispReg;

    // Decode.
    logic       sel;
    logic [5:0] regOff;
    logic       wrEn;
    logic       wrSwEdge;
    logic       wrTimer;
    logic       wrTimerCmp;
    logic       wrStatus;
    logic       wrDisp;

    // Byte lanes are not supported; every access is a full word.
    logic unusedAddrLsb;
    assign unusedAddrLsb = ^bus.AddrIn[1:0];

    assign sel        = (bus.AddrIn[31:8] == BASE_ADDR[31:8]);
    assign regOff     = bus.AddrIn[7:2];
    assign wrEn       = sel && bus.WriteIn;
    assign wrSwEdge   = wrEn && (regOff == OFF_SW_EDGE);
    assign wrTimer    = wrEn && (regOff == OFF_TIMER);
    assign wrTimerCmp = wrEn && (regOff == OFF_TIMER_CMP);
    assign wrStatus   = wrEn && (regOff == OFF_STATUS);
    assign wrDisp     = wrEn && (regOff == OFF_DISP);

    // Next-state logic for the timer, edge capture and match flag.
    logic [31:0] timerNext;
    logic [15:0] preNext;
    logic        timerUpd;
    logic        matchHit;
    logic [15:0] swEdgeNext;
    logic        matchNext;

    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path
        // leaves a value unassigned and no latch is inferred.
        timerNext = timerVal;
        preNext   = preCnt;
        timerUpd  = 1'b0;
        if (wrTimer) begin
            // Software write wins over the increment and restarts the prescaler.
            timerNext = bus.DataIn;
            preNext   = '0;
            timerUpd  = 1'b1;
        end else if (preCnt == PRE_LAST) begin
            timerNext = timerVal + 32'd1;
            preNext   = '0;
            timerUpd  = 1'b1;
        end else begin
            preNext   = preCnt + 16'd1;
        end
    end

    // Only a change of TIMER is compared; writing TIMER_CMP alone never matches.
    assign matchHit = timerUpd && (timerNext == timerCmp);

    // New events are OR-ed in after the W1C clear so they win a same-cycle clear.
    assign swEdgeNext = (swEdge & ~(wrSwEdge ? bus.DataIn[15:0] : 16'h0000))
                      | (swSync2 & ~swHist);
    assign matchNext  = (matchFlag & ~(wrStatus & bus.DataIn[0])) | matchHit;

    // Switch synchronizer, history and edge capture.
    always_ff @(posedge clkIn or negedge rstn) begin
        if (!rstn) begin
            swSync1 <= '0;
            swSync2 <= '0;
            swHist  <= '0;
            swEdge  <= '0;
        end else begin
            // NOTE: non-blocking assignments let each stage sample the value the
            // previous stage held before this edge, giving a true shift chain.
            swSync1 <= sw_i;
            swSync2 <= swSync1;
            swHist  <= swSync2;
            swEdge  <= swEdgeNext;
        end
    end

    // Timer, prescaler, compare, status and display.
    always_ff @(posedge clkIn or negedge rstn) begin
        if (!rstn) begin
            timerVal  <= '0;
            preCnt    <= '0;
            timerCmp  <= '0;
            matchFlag <= 1'b0;
            dispReg   <= '0;
        end else begin
            timerVal  <= timerNext;
            preCnt    <= preNext;
            matchFlag <= matchNext;
            if (wrTimerCmp) begin
                timerCmp <= bus.DataIn;
            end
            if (wrDisp) begin
                dispReg <= bus.DataIn;
            end
        end
    end

    // Read mux: combinational, shows pre-write values during a read+write cycle.
    logic [31:0] rdData;

    always_comb begin
        rdData = '0;
        case (regOff)
            OFF_SW_DATA:   rdData = {16'h0000, swSync2};
            OFF_SW_EDGE:   rdData = {16'h0000, swEdge};
            OFF_TIMER:     rdData = timerVal;
            OFF_TIMER_CMP: rdData = timerCmp;
            OFF_STATUS:    rdData = {31'h0, matchFlag};
            OFF_DISP:      rdData = dispReg;
            default:       rdData = '0;
        endcase
    end

    assign bus.SelOut  = sel;
    assign bus.DataOut = (sel && bus.ReadIn) ? rdData : 32'h0;
    assign dispOut     = dispReg;
    assign irqOut      = matchFlag;

endmodule

// File: tb/tb_mmio_responder.sv
// ---------------------------------------------------------------------------
// tb_mmio_responder
//   Two responders: dutA with TIMER_DIV=4 tracked by a behavioural model,
//   dutB with TIMER_DIV=1 used for the timer wrap scenario.
// ---------------------------------------------------------------------------
module tb_mmio_responder;

    localparam logic [31:0] BASE  = 32'hFFFF_FF00;
    localparam int          DIV_A = 4;

    logic        clkIn = 1'b0;
    logic        rstn;
    logic [15:0] sw_i;
    logic [31:0] dispA, dispB;
    logic        irqA, irqB;

    int errors = 0;
    int checks = 0;

    mmio_responder_if busA ();
    mmio_responder_if busB ();

    mmio_responder #(.BASE_ADDR(BASE), .TIMER_DIV(DIV_A)) dutA (
        .clkIn(clkIn), .rstn(rstn), .bus(busA), .sw_i(sw_i),
        .dispOut(dispA), .irqOut(irqA)
    );

    mmio_responder #(.BASE_ADDR(BASE), .TIMER_DIV(1)) dutB (
        .clkIn(clkIn), .rstn(rstn), .bus(busB), .sw_i(sw_i),
        .dispOut(dispB), .irqOut(irqB)
    );

    always #5 clkIn = ~clkIn;

    // ---------------- behavioural model of dutA ----------------
    logic [15:0] mTaps [3];   // switch samples seen over the last three edges
    logic [15:0] mEdge;
    logic [31:0] mTimer;
    int          mTicks;      // edges since reset or last TIMER write
    logic [31:0] mCmp;
    logic        mStatus;
    logic [31:0] mDisp;

    task automatic modelReset();
        for (int i = 0; i < 3; i++) mTaps[i] = '0;
        mEdge = '0; mTimer = '0; mTicks = 0; mCmp = '0; mStatus = 1'b0; mDisp = '0;
    endtask

    function automatic logic [31:0] modelRead(input logic [5:0] off);
        case (off)
            6'd0:    return {16'h0, mTaps[1]};
            6'd1:    return {16'h0, mEdge};
            6'd2:    return mTimer;
            6'd3:    return mCmp;
            6'd4:    return {31'h0, mStatus};
            6'd5:    return mDisp;
            default: return 32'h0;
        endcase
    endfunction

    task automatic modelStep();
        logic       sel;
        logic [5:0] off;
        logic       wr;
        logic [31:0] d;
        logic       bumped;
        sel = (busA.AddrIn[31:8] == BASE[31:8]);
        off = busA.AddrIn[7:2];
        wr  = sel && busA.WriteIn;
        d   = busA.DataIn;
        if (wr && off == 6'd1) mEdge = mEdge & ~d[15:0];
        mEdge = mEdge | (mTaps[1] & ~mTaps[2]);
        mTaps[2] = mTaps[1]; mTaps[1] = mTaps[0]; mTaps[0] = sw_i;
        bumped = 1'b0;
        if (wr && off == 6'd2) begin
            mTimer = d; mTicks = 0; bumped = 1'b1;
        end else begin
            mTicks++;
            if (mTicks % DIV_A == 0) begin
                mTimer = mTimer + 32'd1; bumped = 1'b1;
            end
        end
        if (wr && off == 6'd4 && d[0]) mStatus = 1'b0;
        if (bumped && mTimer == mCmp) mStatus = 1'b1;
        if (wr && off == 6'd3) mCmp = d;
        if (wr && off == 6'd5) mDisp = d;
    endtask

    // ---------------- stimulus helpers ----------------
    function automatic logic [31:0] addrOf(input int off);
        return BASE + 32'(off * 4);
    endfunction

    task automatic setA(input logic [31:0] a, input logic [31:0] d, input logic r, input logic w);
        busA.AddrIn = a; busA.DataIn = d; busA.ReadIn = r; busA.WriteIn = w;
    endtask

    task automatic setB(input logic [31:0] a, input logic [31:0] d, input logic r, input logic w);
        busB.AddrIn = a; busB.DataIn = d; busB.ReadIn = r; busB.WriteIn = w;
    endtask

    task automatic rdA(input int off, output logic [31:0] v);
        setA(addrOf(off), 32'h0, 1'b1, 1'b0);
        #1;
        v = busA.DataOut;
    endtask

    // Advance one clock: model sees the inputs present at the edge.
    task automatic cycle();
        if (rstn) modelStep();
        @(posedge clkIn);
        @(negedge clkIn);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rstn = 1'b0; sw_i = '0;
        setA(32'h0, 32'h0, 1'b0, 1'b0);
        setB(32'h0, 32'h0, 1'b0, 1'b0);
        #12;
        checks++; if (dispA !== 32'h0) begin errors++; $display("FAIL reset_disp: got %h want 0", dispA); end
        checks++; if (irqA !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b want 0", irqA); end
        checks++; if (irqB !== 1'b0) begin errors++; $display("FAIL reset_irqB: got %b want 0", irqB); end
        for (int off = 0; off < 6; off++) begin
            setA(addrOf(off), 32'h0, 1'b1, 1'b0);
            #1;
            checks++; if (busA.SelOut !== 1'b1) begin errors++; $display("FAIL reset_sel off%0d: got %b want 1", off, busA.SelOut); end
            checks++; if (busA.DataOut !== 32'h0) begin errors++; $display("FAIL reset_read off%0d: got %h want 0", off, busA.DataOut); end
        end
        setA(32'h0000_0010, 32'h0, 1'b1, 1'b0);
        #1;
        checks++; if (busA.SelOut !== 1'b0) begin errors++; $display("FAIL outside_sel: got %b want 0", busA.SelOut); end
        checks++; if (busA.DataOut !== 32'h0) begin errors++; $display("FAIL outside_read: got %h want 0", busA.DataOut); end
        @(negedge clkIn);
        modelReset();
        setA(32'h0, 32'h0, 1'b0, 1'b0);
        rstn = 1'b1;
    endtask

    task automatic test_disp();
        logic [31:0] v;
        setA(addrOf(5), 32'h1234_5678, 1'b0, 1'b1);
        cycle();
        checks++; if (dispA !== 32'h1234_5678) begin errors++; $display("FAIL disp_write: got %h want 12345678", dispA); end
        rdA(5, v);
        checks++; if (v !== 32'h1234_5678) begin errors++; $display("FAIL disp_read: got %h want 12345678", v); end
        setA(32'h0000_0014, 32'hDEAD_BEEF, 1'b1, 1'b1);
        #1;
        checks++; if (busA.DataOut !== 32'h0) begin errors++; $display("FAIL disp_outside_read: got %h want 0", busA.DataOut); end
        cycle();
        checks++; if (dispA !== 32'h1234_5678) begin errors++; $display("FAIL disp_outside_write: got %h want 12345678", dispA); end
    endtask

    task automatic test_switches();
        logic [31:0] v;
        sw_i = 16'h0005;
        rdA(0, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL sw_data_0edges: got %h want 0", v); end
        cycle();
        rdA(0, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL sw_data_1edge: got %h want 0", v); end
        cycle();
        rdA(0, v);
        checks++; if (v !== 32'h5) begin errors++; $display("FAIL sw_data_2edges: got %h want 5", v); end
        rdA(1, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL sw_edge_2edges: got %h want 0", v); end
        cycle();
        rdA(1, v);
        checks++; if (v !== 32'h5) begin errors++; $display("FAIL sw_edge_3edges: got %h want 5", v); end
        // Read and W1C in the same cycle: read shows the pre-write value.
        setA(addrOf(1), 32'h1, 1'b1, 1'b1);
        #1;
        checks++; if (busA.DataOut !== 32'h5) begin errors++; $display("FAIL sw_edge_rw_prewrite: got %h want 5", busA.DataOut); end
        cycle();
        rdA(1, v);
        checks++; if (v !== 32'h4) begin errors++; $display("FAIL sw_edge_w1c: got %h want 4", v); end
        sw_i = 16'h0000;
        repeat (4) cycle();
        rdA(1, v);
        checks++; if (v !== 32'h4) begin errors++; $display("FAIL sw_edge_fall: got %h want 4", v); end
        rdA(0, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL sw_data_fall: got %h want 0", v); end
    endtask

    task automatic test_timer();
        logic [31:0] v;
        setA(addrOf(3), 32'd3, 1'b0, 1'b1);
        cycle();
        setA(addrOf(2), 32'd0, 1'b0, 1'b1);
        cycle();
        setA(addrOf(2), 32'h0, 1'b1, 1'b0);
        repeat (11) cycle();
        rdA(2, v);
        checks++; if (v !== 32'd2) begin errors++; $display("FAIL timer_11edges: got %h want 2", v); end
        rdA(4, v);
        checks++; if (v !== 32'd0) begin errors++; $display("FAIL status_before_match: got %h want 0", v); end
        cycle();
        rdA(2, v);
        checks++; if (v !== 32'd3) begin errors++; $display("FAIL timer_12edges: got %h want 3", v); end
        rdA(4, v);
        checks++; if (v !== 32'd1) begin errors++; $display("FAIL status_match: got %h want 1", v); end
        checks++; if (irqA !== 1'b1) begin errors++; $display("FAIL irq_match: got %b want 1", irqA); end
        repeat (8) cycle();
        rdA(2, v);
        checks++; if (v !== 32'd5) begin errors++; $display("FAIL timer_20edges: got %h want 5", v); end
        checks++; if (irqA !== 1'b1) begin errors++; $display("FAIL irq_sticky: got %b want 1", irqA); end
        setA(addrOf(4), 32'h1, 1'b0, 1'b1);
        cycle();
        rdA(4, v);
        checks++; if (v !== 32'd0) begin errors++; $display("FAIL status_w1c: got %h want 0", v); end
        checks++; if (irqA !== 1'b0) begin errors++; $display("FAIL irq_w1c: got %b want 0", irqA); end
        // Compare written to the current TIMER value must not raise the flag.
        setA(addrOf(2), 32'd7, 1'b0, 1'b1);
        cycle();
        setA(addrOf(3), 32'd7, 1'b0, 1'b1);
        cycle();
        rdA(2, v);
        checks++; if (v !== 32'd7) begin errors++; $display("FAIL timer_hold_after_write: got %h want 7", v); end
        checks++; if (irqA !== 1'b0) begin errors++; $display("FAIL cmp_write_no_match: got %b want 0", irqA); end
        setA(32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic test_wrap();
        checks++; if (irqB !== 1'b0) begin errors++; $display("FAIL wrap_irq_before: got %b want 0", irqB); end
        setB(addrOf(2), 32'hFFFF_FFFE, 1'b0, 1'b1);
        cycle();
        setB(addrOf(2), 32'h0, 1'b1, 1'b0);
        #1;
        checks++; if (busB.DataOut !== 32'hFFFF_FFFE) begin errors++; $display("FAIL wrap_write: got %h want fffffffe", busB.DataOut); end
        cycle();
        #1;
        checks++; if (busB.DataOut !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_max: got %h want ffffffff", busB.DataOut); end
        checks++; if (irqB !== 1'b0) begin errors++; $display("FAIL wrap_irq_max: got %b want 0", irqB); end
        cycle();
        #1;
        checks++; if (busB.DataOut !== 32'h0) begin errors++; $display("FAIL wrap_zero: got %h want 0", busB.DataOut); end
        checks++; if (irqB !== 1'b1) begin errors++; $display("FAIL wrap_match_zero: got %b want 1", irqB); end
        setB(32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic test_edge_priority();
        logic [31:0] v;
        setA(addrOf(1), 32'h4, 1'b0, 1'b1);
        cycle();
        rdA(1, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL edge_clear: got %h want 0", v); end
        sw_i = 16'h0004;
        setA(addrOf(1), 32'h4, 1'b0, 1'b1);
        repeat (3) cycle();
        rdA(1, v);
        checks++; if (v !== 32'h4) begin errors++; $display("FAIL edge_beats_w1c: got %h want 4", v); end
        setA(32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        logic [31:0] a, d, expD;
        logic        r, w, expSel;
        int          off;
        for (int n = 0; n < 500; n++) begin
            if ($urandom_range(0, 3) == 0) sw_i = 16'($urandom);
            if ($urandom_range(0, 9) < 8) begin
                off = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 7));
                a = addrOf(off) | 32'($urandom_range(0, 3));
            end else begin
                a = {8'h00, 24'($urandom)};
                off = int'(a[7:2]);
            end
            r = ($urandom_range(0, 9) < 6);
            w = ($urandom_range(0, 9) < 4);
            d = $urandom;
            if (off == 2 && $urandom_range(0, 1) == 1) d = mCmp - 32'($urandom_range(0, 2));
            if (off == 3 && $urandom_range(0, 1) == 1) d = mTimer + 32'($urandom_range(0, 3));
            setA(a, d, r, w);
            #1;
            expSel = (a[31:8] == BASE[31:8]);
            expD   = (expSel && r) ? modelRead(a[7:2]) : 32'h0;
            checks++; if (busA.SelOut !== expSel) begin errors++; $display("FAIL rand_sel n%0d: got %b want %b", n, busA.SelOut, expSel); end
            checks++; if (busA.DataOut !== expD) begin errors++; $display("FAIL rand_read n%0d addr %h: got %h want %h", n, a, busA.DataOut, expD); end
            checks++; if (dispA !== mDisp) begin errors++; $display("FAIL rand_disp n%0d: got %h want %h", n, dispA, mDisp); end
            checks++; if (irqA !== mStatus) begin errors++; $display("FAIL rand_irq n%0d: got %b want %b", n, irqA, mStatus); end
            cycle();
        end
        setA(32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid();
        logic [31:0] v;
        setA(addrOf(5), 32'hA5A5_A5A5, 1'b0, 1'b1);
        cycle();
        setA(addrOf(3), 32'h55, 1'b0, 1'b1);
        cycle();
        setA(addrOf(2), 32'h55, 1'b0, 1'b1);
        cycle();
        checks++; if (irqA !== 1'b1) begin errors++; $display("FAIL pre_reset_irq: got %b want 1", irqA); end
        setA(32'h0, 32'h0, 1'b0, 1'b0);
        sw_i = 16'hFFFF;
        repeat (2) cycle();
        #2;
        rstn = 1'b0;
        #1;
        checks++; if (dispA !== 32'h0) begin errors++; $display("FAIL midreset_disp: got %h want 0", dispA); end
        checks++; if (irqA !== 1'b0) begin errors++; $display("FAIL midreset_irq: got %b want 0", irqA); end
        checks++; if (irqB !== 1'b0) begin errors++; $display("FAIL midreset_irqB: got %b want 0", irqB); end
        for (int off = 0; off < 6; off++) begin
            setA(addrOf(off), 32'h0, 1'b1, 1'b0);
            #1;
            checks++; if (busA.DataOut !== 32'h0) begin errors++; $display("FAIL midreset_read off%0d: got %h want 0", off, busA.DataOut); end
        end
        @(negedge clkIn);
        modelReset();
        setA(32'h0, 32'h0, 1'b0, 1'b0);
        rstn = 1'b1;
        repeat (3) cycle();
        rdA(2, v);
        checks++; if (v !== 32'd0) begin errors++; $display("FAIL postreset_prescale: got %h want 0", v); end
        rdA(1, v);
        checks++; if (v !== modelRead(6'd1)) begin errors++; $display("FAIL postreset_edge: got %h want %h", v, modelRead(6'd1)); end
        cycle();
        rdA(2, v);
        checks++; if (v !== 32'd1) begin errors++; $display("FAIL postreset_timer: got %h want 1", v); end
    endtask

    initial begin
        test_reset();
        test_disp();
        test_switches();
        test_timer();
        test_wrap();
        test_edge_priority();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mmio_responder.md
# mmio_responder

Memory-mapped I/O responder on the pipeline's data-memory bus. It answers MEM-stage loads and stores whose address falls in the I/O window, alongside DMem. It owns a synchronized switch-input port with edge capture, a prescaled 32-bit timer with compare-match flag, and a 32-bit display register that feeds the seg7 driver. The top level muxes DataOut between DMem and this block using SelOut.

## Interface

- BASE_ADDR, 32'hFFFF_FF00, base of the 256-byte I/O window; bits [7:0] must be zero
- TIMER_DIV, 1, clkIn cycles per timer increment; legal range 1..65535
- clkIn  input  1  pipeline clock; all state updates on rising edge
- rstn  input  1  asynchronous, active-low reset
- AddrIn  input  32  byte address from EX/MEM ALU result
- DataIn  input  32  store data from EX/MEM rs2 value
- ReadIn  input  1  load strobe, EX/MEM control bit 8
- WriteIn  input  1  store strobe, EX/MEM control bit 7
- sw_i  input  16  raw board switches, asynchronous to clkIn
- SelOut  output  1  AddrIn is inside the window; combinational
- DataOut  output  32  read data; combinational
- dispOut  output  32  display register value
- irqOut  output  1  copy of the timer-match sticky flag

## Operation

- Decode: SelOut = (AddrIn[31:8] == BASE_ADDR[31:8]). Register offset = AddrIn[7:2]; AddrIn[1:0] ignored; all accesses are full-word.
- Register map, by offset:
  - 0x00 SW_DATA, RO: 16-bit synchronized switches, zero-extended.
  - 0x04 SW_EDGE, R/W1C: bit i is set on a 0->1 transition of synchronized sw i. Writing 1 clears that bit.
  - 0x08 TIMER, RW: 32-bit up-counter.
  - 0x0C TIMER_CMP, RW.
  - 0x10 STATUS: bit0 is the match flag, W1C; bits 31:1 read 0.
  - 0x14 DISP, RW: drives dispOut.
  - Other offsets read 0; writes to them are ignored.
- Read: DataOut = selected register when SelOut && ReadIn; otherwise 0. A read has no side effects; reading SW_EDGE does not clear it.
- Write: takes effect at the clkIn edge when SelOut && WriteIn. Writes with SelOut=0 are ignored.
- Synchronizer: two flops on sw_i. An edge is detected by comparing sync stage 2 with a third, history flop.
- Prescaler: counter 0..TIMER_DIV-1. When it wraps, TIMER increments. TIMER wraps 32'hFFFF_FFFF -> 0.
- Match: the cycle TIMER's new value equals TIMER_CMP, STATUS.bit0 is set and stays set (sticky).
- Priorities:
  - A write to TIMER beats an increment in the same cycle. The prescaler resets to 0 on a TIMER write.
  - A new edge or match event beats a W1C clear of the same bit in the same cycle; the bit stays 1.
  - Simultaneous ReadIn and WriteIn: DataOut shows the pre-write value, and the write lands at the edge.
  - A TIMER_CMP write that makes TIMER_CMP equal the current TIMER does not set the match flag. Only a TIMER update (increment or write) is checked.

## Timing

- Reset (rstn low, asynchronous): sync flops, history, SW_EDGE, TIMER, prescaler, TIMER_CMP, STATUS and DISP go to 0. dispOut=0 and irqOut=0 immediately; DataOut is 0 unless a read is selected.
- Reset mid-operation discards a pending prescale count and any captured edges.
- Read latency 0: data is valid in the same cycle as the MEM-stage strobe, matching DMem.
- Write latency 1: register value changes at the clkIn edge ending the store cycle. dispOut and irqOut follow on that edge.
- Switch to SW_DATA latency: 2 edges. Switch rise to SW_EDGE bit set: 3 edges after the input changes.
- Timer with TIMER_DIV=N: TIMER increments once per N edges after reset release.
- Match flag sets on the same edge that TIMER takes the compared value.

## Test plan

- Reset, then read 0xFFFFFF00..0xFFFFFF14 -> every read returns 0; dispOut=0; irqOut=0; SelOut=1 for each, SelOut=0 for address 0x00000010.
- Store 0x12345678 to 0xFFFFFF14 -> dispOut=0x12345678 on the next edge; a load of the same address returns 0x12345678; a store to 0x00000014 leaves DISP unchanged.
- Drive sw_i=0x0005 -> SW_DATA reads 0x0005 after 2 edges and SW_EDGE reads 0x0005 after 3. Write 0x0001 to SW_EDGE -> it reads 0x0004. Drop sw_i to 0 -> SW_EDGE stays 0x0004.
- TIMER_DIV=4: write TIMER_CMP=3 -> TIMER reaches 3 after 12 edges; STATUS=1 and irqOut=1 on that edge; still 1 after TIMER passes 4; writing 1 to STATUS clears it.
- Write TIMER=0xFFFFFFFE with TIMER_DIV=1 -> reads 0xFFFFFFFF, then 0. The write cycle itself does not increment.
- Hold a W1C of SW_EDGE bit 2 in the same cycle a new rise on sw 2 is detected -> bit 2 reads 1. Assert rstn low mid-count -> all state is 0 immediately.
